// File: rtl/prog_loader_pkg.sv
// Shared loader definitions: FSM state codes and frame-format constants.
// Imported by the loader top and its byte packer.
package prog_loader_pkg;

  typedef logic [2:0] ld_state_t;

  localparam logic [2:0] LD_LEN  = 3'd0;
  localparam logic [2:0] LD_DATA = 3'd1;
  localparam logic [2:0] LD_CHK  = 3'd2;
  localparam logic [2:0] LD_DONE = 3'd3;
  localparam logic [2:0] LD_ERR  = 3'd4;

  localparam int BYTES_PER_WORD = 4;

  function automatic logic accepts(input ld_state_t s);
    return (s == LD_LEN) || (s == LD_DATA) || (s == LD_CHK);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Byte-to-word packer: MSB-first shift register, byte index and XOR checksum.
// word_ready flags the transfer that completes a word; word_nxt is that word.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift,
  input  logic [7:0]  din,
  output logic        word_ready,
  output logic [31:0] word_nxt,
  output logic [7:0]  csum
);
  import prog_loader_pkg::*;

  logic [31:0] word;
  logic [1:0]  idx;

  assign word_nxt   = {word[23:0], din};
  assign word_ready = shift && (idx == 2'(BYTES_PER_WORD - 1));

  // Shift bytes in, track position within the word, fold into checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
      csum <= '0;
    end else if (clr) begin
      word <= '0;
      idx  <= '0;
      csum <= '0;
    end else if (shift) begin
      word <= word_nxt;
      idx  <= idx + 2'd1;
      csum <= csum ^ din;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Instruction RAM loader: frames a byte stream into words, writes the RAM,
// and releases the CPU from reset only after the checksum matches.
module prog_loader #(
  parameter int ADDR_W      = 6,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_a,
  output logic [31:0]       ram_d,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);
  import prog_loader_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NW    = ADDR_W + 1;
  localparam int CW    = $clog2(TIMEOUT_CYC) + 1;

  ld_state_t         state;
  ld_state_t         state_nxt;
  logic [NW-1:0]     n_words;
  logic [ADDR_W-1:0] widx;
  logic [CW-1:0]     idle;

  logic        xfer;
  logic        len_bad;
  logic        last_word;
  logic        timeout;
  logic        chk_ok;
  logic        word_ready;
  logic [31:0] word_nxt;
  logic [7:0]  csum;

  assign xfer      = in_valid && in_ready;
  assign len_bad   = (in_data == 8'd0) ||
                     ({24'd0, in_data} > 32'(DEPTH));
  assign last_word = ({1'b0, widx} + NW'(1)) == n_words;
  assign timeout   = (idle == CW'(TIMEOUT_CYC - 1));
  assign chk_ok    = (in_data == csum);

  byte_packer u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (xfer && (state == LD_LEN)),
    .shift      (xfer && (state == LD_DATA)),
    .din        (in_data),
    .word_ready (word_ready),
    .word_nxt   (word_nxt),
    .csum       (csum)
  );

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      LD_LEN: begin
        if (xfer) state_nxt = len_bad ? LD_ERR : LD_DATA;
      end
      LD_DATA: begin
        if (xfer) begin
          if (word_ready && last_word) state_nxt = LD_CHK;
        end else if (timeout) begin
          state_nxt = LD_ERR;
        end
      end
      LD_CHK: begin
        if (xfer) state_nxt = chk_ok ? LD_DONE : LD_ERR;
        else if (timeout) state_nxt = LD_ERR;
      end
      LD_DONE, LD_ERR: begin
        if (reload) state_nxt = LD_LEN;
      end
      default: state_nxt = LD_LEN;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LD_LEN;
    else        state <= state_nxt;
  end

  // Frame length capture and word index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_words <= '0;
      widx    <= '0;
    end else if (xfer && (state == LD_LEN)) begin
      n_words <= NW'(in_data);
      widx    <= '0;
    end else if (word_ready) begin
      widx    <= widx + ADDR_W'(1);
    end
  end

  // Idle counter between accepted bytes while a frame is open
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle <= '0;
    end else if ((state == LD_DATA) || (state == LD_CHK)) begin
      idle <= xfer ? '0 : idle + CW'(1);
    end else begin
      idle <= '0;
    end
  end

  // RAM write port: one-cycle strobe after each completed word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we <= 1'b0;
      ram_a  <= '0;
      ram_d  <= '0;
    end else begin
      ram_we <= word_ready;
      if (word_ready) begin
        ram_a <= widx;
        ram_d <= word_nxt;
      end
    end
  end

  // Registered status outputs follow the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      in_ready  <= accepts(state_nxt);
      cpu_rst_n <= (state_nxt == LD_DONE);
      done      <= (state_nxt == LD_DONE);
      err       <= (state_nxt == LD_ERR);
    end
  end

endmodule
